writeback_trace_buffer: RTL and testbench

- Synthesizable commit-trace recorder, directly downstream of the processor's regfile write port (ctrl_writeEnable / ctrl_writeReg / data_writeReg).
- Timestamps every architectural register write and queues it as {cycle, reg, data} in a FIFO.
- Drains the FIFO over a ready/valid interface to a logger, UART bridge or bench, in place of per-cycle text dumps.
- Instantiated in the wrapper alongside the processor, regfile and memories; it taps the write port and never drives it.

---
 rtl/wbtrace_pkg.sv | 15 +
 rtl/sync_fifo.sv | 52 +++++
 rtl/writeback_trace_buffer.sv | 100 ++++++++++
 tb/tb_writeback_trace_buffer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wbtrace_pkg.sv
// Shared widths and the default trace-entry layout for the writeback trace buffer.
package wbtrace_pkg;

  localparam int REG_W       = 5;
  localparam int DATA_W      = 32;
  localparam int DROP_CNT_W  = 16;
  localparam int CYCLE_W_DEF = 16;

  typedef struct packed {
    logic [CYCLE_W_DEF-1:0] cycle;
    logic [REG_W-1:0]       wreg;
    logic [DATA_W-1:0]      data;
  } trace_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous show-ahead FIFO: rd_data always presents the head entry.
// The caller guarantees push only when not full (or popping) and pop only when not empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage carries no reset; stale contents are never visible because count gates them.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/writeback_trace_buffer.sv
// Timestamps regfile writes and queues them as {cycle, reg, data} for a ready/valid consumer.
// Optional macro WBTRACE_DROP_CNT_EN adds drop_count and trace_include_x0.
module writeback_trace_buffer
  import wbtrace_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int CYCLE_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   capture_en,
  input  logic                   ctrl_writeEnable,
  input  logic [REG_W-1:0]       ctrl_writeReg,
  input  logic [DATA_W-1:0]      data_writeReg,
  input  logic                   trace_ready,
  output logic                   trace_valid,
  output logic [CYCLE_W-1:0]     trace_cycle,
  output logic [REG_W-1:0]       trace_reg,
  output logic [DATA_W-1:0]      trace_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   overflow
`ifdef WBTRACE_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0]  drop_count,
  input  logic                   trace_include_x0
`endif
);

  typedef struct packed {
    logic [CYCLE_W-1:0] cycle;
    logic [REG_W-1:0]   wreg;
    logic [DATA_W-1:0]  data;
  } entry_t;

  logic [CYCLE_W-1:0] cycle_q;
  logic               capture;
  logic               push;
  logic               pop;
  logic               drop;
  logic               fifo_empty;
  entry_t             wr_entry;
  entry_t             head;

`ifdef WBTRACE_DROP_CNT_EN
  assign capture = capture_en && ctrl_writeEnable &&
                   ((ctrl_writeReg != '0) || trace_include_x0);
`else
  assign capture = capture_en && ctrl_writeEnable && (ctrl_writeReg != '0);
`endif

  // A pop frees the slot in the same edge, so a full FIFO can still accept a capture.
  assign pop  = trace_valid && trace_ready;
  assign push = capture && (!full || pop);
  assign drop = capture && full && !pop;

  assign wr_entry = '{cycle: cycle_q, wreg: ctrl_writeReg, data: data_writeReg};

  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_q  <= '0;
      overflow <= 1'b0;
    end else begin
      cycle_q <= cycle_q + CYCLE_W'(1);
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef WBTRACE_DROP_CNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      drop_count <= '0;
    end else if (drop && (drop_count != '1)) begin
      drop_count <= drop_count + DROP_CNT_W'(1);
    end
  end
`endif

  sync_fifo #(
    .WIDTH($bits(entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (fifo_empty)
  );

  // Head fields are forced to zero while empty so consumers never see stale storage.
  assign trace_valid = !fifo_empty;
  assign trace_cycle = trace_valid ? head.cycle : '0;
  assign trace_reg   = trace_valid ? head.wreg  : '0;
  assign trace_data  = trace_valid ? head.data  : '0;

endmodule

// File: tb/tb_writeback_trace_buffer.sv
// Directed self-checking bench for writeback_trace_buffer (DEPTH=16/CYCLE_W=16 plus a CYCLE_W=4 copy).
module tb_writeback_trace_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic        capture_en;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        trace_ready;

  logic        trace_valid;
  logic [15:0] trace_cycle;
  logic [4:0]  trace_reg;
  logic [31:0] trace_data;
  logic [4:0]  count;
  logic        full;
  logic        overflow;

  logic        t4_valid;
  logic [3:0]  t4_cycle;
  logic [4:0]  t4_reg;
  logic [31:0] t4_data;
  logic [2:0]  t4_count;
  logic        t4_full;
  logic        t4_overflow;

`ifdef WBTRACE_DROP_CNT_EN
  logic [15:0] drop_count;
  logic [15:0] t4_drop_count;
  logic        trace_include_x0;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  writeback_trace_buffer #(.DEPTH(16), .CYCLE_W(16)) dut (
    .clock            (clock),
    .reset            (reset),
    .capture_en       (capture_en),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .trace_ready      (trace_ready),
    .trace_valid      (trace_valid),
    .trace_cycle      (trace_cycle),
    .trace_reg        (trace_reg),
    .trace_data       (trace_data),
    .count            (count),
    .full             (full),
    .overflow         (overflow)
`ifdef WBTRACE_DROP_CNT_EN
    ,
    .drop_count       (drop_count),
    .trace_include_x0 (trace_include_x0)
`endif
  );

  writeback_trace_buffer #(.DEPTH(4), .CYCLE_W(4)) dut4 (
    .clock            (clock),
    .reset            (reset),
    .capture_en       (capture_en),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .trace_ready      (trace_ready),
    .trace_valid      (t4_valid),
    .trace_cycle      (t4_cycle),
    .trace_reg        (t4_reg),
    .trace_data       (t4_data),
    .count            (t4_count),
    .full             (t4_full),
    .overflow         (t4_overflow)
`ifdef WBTRACE_DROP_CNT_EN
    ,
    .drop_count       (t4_drop_count),
    .trace_include_x0 (trace_include_x0)
`endif
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic set_write(input logic [4:0] r, input logic [31:0] d);
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = r;
    data_writeReg    = d;
  endtask

  task automatic clear_write;
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = '0;
    data_writeReg    = '0;
  endtask

  // Reset with a write pending on the same edge, then idle pops on an empty FIFO.
  task automatic test_reset;
    capture_en  = 1'b1;
    trace_ready = 1'b0;
    set_write(5'd5, 32'd1);
    do_reset();
    clear_write();
    checks++; if (count !== 5'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
    checks++; if (trace_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", trace_valid); end
    checks++; if (full !== 1'b0 || overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: got full=%0b overflow=%0b expected 0/0", full, overflow); end
    checks++; if (trace_cycle !== 16'd0 || trace_reg !== 5'd0 || trace_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_head: got %0d/%0d/%0d expected 0/0/0", trace_cycle, trace_reg, trace_data); end
    trace_ready = 1'b1;
    repeat (3) tick();
    checks++; if (count !== 5'd0) begin errors++; $display("[TB] FAIL empty_pop_count: got %0d expected 0", count); end
    trace_ready = 1'b0;
    set_write(5'd6, 32'd7);
    tick();
    clear_write();
    checks++; if (count !== 5'd1 || trace_cycle !== 16'd3) begin errors++; $display("[TB] FAIL after_empty_pop: got count=%0d cycle=%0d expected 1/3", count, trace_cycle); end
  endtask

  task automatic test_basic;
    clear_write();
    trace_ready = 1'b0;
    do_reset();
    repeat (3) tick();
    set_write(5'd5, 32'd42);
    tick();
    clear_write();
    checks++; if (trace_valid !== 1'b1 || count !== 5'd1) begin errors++; $display("[TB] FAIL basic_valid: got valid=%0b count=%0d expected 1/1", trace_valid, count); end
    checks++; if (trace_cycle !== 16'd3 || trace_reg !== 5'd5 || trace_data !== 32'd42) begin errors++; $display("[TB] FAIL basic_head: got %0d/%0d/%0d expected 3/5/42", trace_cycle, trace_reg, trace_data); end
    tick();
    checks++; if (trace_cycle !== 16'd3 || trace_data !== 32'd42 || count !== 5'd1) begin errors++; $display("[TB] FAIL basic_hold: got cycle=%0d data=%0d count=%0d expected 3/42/1", trace_cycle, trace_data, count); end
    trace_ready = 1'b1;
    tick();
    trace_ready = 1'b0;
    checks++; if (trace_valid !== 1'b0 || count !== 5'd0 || trace_data !== 32'd0) begin errors++; $display("[TB] FAIL basic_pop: got valid=%0b count=%0d data=%0d expected 0/0/0", trace_valid, count, trace_data); end
  endtask

  task automatic test_x0;
    clear_write();
    trace_ready = 1'b0;
`ifdef WBTRACE_DROP_CNT_EN
    trace_include_x0 = 1'b0;
`endif
    do_reset();
    repeat (2) tick();
    set_write(5'd0, 32'd99);
    tick();
    clear_write();
    checks++; if (count !== 5'd0) begin errors++; $display("[TB] FAIL x0_ignored: got count=%0d expected 0", count); end
    capture_en = 1'b0;
    set_write(5'd3, 32'd1);
    tick();
    clear_write();
    capture_en = 1'b1;
    checks++; if (count !== 5'd0) begin errors++; $display("[TB] FAIL capture_disabled: got count=%0d expected 0", count); end
`ifdef WBTRACE_DROP_CNT_EN
    trace_include_x0 = 1'b1;
    do_reset();
    repeat (2) tick();
    set_write(5'd0, 32'd99);
    tick();
    clear_write();
    checks++; if (count !== 5'd1 || trace_cycle !== 16'd2 || trace_reg !== 5'd0 || trace_data !== 32'd99) begin errors++; $display("[TB] FAIL x0_included: got count=%0d head=%0d/%0d/%0d expected 1 2/0/99", count, trace_cycle, trace_reg, trace_data); end
    trace_include_x0 = 1'b0;
`endif
  endtask

  // Fill with 17 writes: entry i is {i, i+1, 100+i}; the 17th is dropped.
  task automatic test_full;
    clear_write();
    trace_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      set_write(5'(i + 1), 32'(100 + i));
      tick();
      if (i == 15) begin
        checks++; if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin errors++; $display("[TB] FAIL just_full: got full=%0b count=%0d overflow=%0b expected 1/16/0", full, count, overflow); end
      end
    end
    clear_write();
    checks++; if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b1) begin errors++; $display("[TB] FAIL overflow: got full=%0b count=%0d overflow=%0b expected 1/16/1", full, count, overflow); end
    checks++; if (trace_cycle !== 16'd0 || trace_reg !== 5'd1 || trace_data !== 32'd100) begin errors++; $display("[TB] FAIL full_head: got %0d/%0d/%0d expected 0/1/100", trace_cycle, trace_reg, trace_data); end
`ifdef WBTRACE_DROP_CNT_EN
    checks++; if (drop_count !== 16'd1) begin errors++; $display("[TB] FAIL drop_count: got %0d expected 1", drop_count); end
`endif
  endtask

  // Continues from a full FIFO: pop and push on the same edge.
  task automatic test_back_to_back;
    trace_ready = 1'b1;
    set_write(5'd7, 32'hDEADBEEF);
    tick();
    clear_write();
    checks++; if (count !== 5'd16 || overflow !== 1'b1) begin errors++; $display("[TB] FAIL full_pushpop_count: got count=%0d overflow=%0b expected 16/1", count, overflow); end
    checks++; if (trace_cycle !== 16'd1 || trace_reg !== 5'd2 || trace_data !== 32'd101) begin errors++; $display("[TB] FAIL full_pushpop_head: got %0d/%0d/%0d expected 1/2/101", trace_cycle, trace_reg, trace_data); end
    repeat (15) tick();
    trace_ready = 1'b0;
    checks++; if (count !== 5'd1 || trace_cycle !== 16'd17 || trace_reg !== 5'd7 || trace_data !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL tail_entry: got count=%0d head=%0d/%0d/%h expected 1 17/7/deadbeef", count, trace_cycle, trace_reg, trace_data); end
`ifdef WBTRACE_DROP_CNT_EN
    checks++; if (drop_count !== 16'd1) begin errors++; $display("[TB] FAIL drop_count_hold: got %0d expected 1", drop_count); end
`endif
  endtask

  task automatic test_reset_mid;
    clear_write();
    trace_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      set_write(5'(i + 1), 32'(200 + i));
      tick();
    end
    clear_write();
    trace_ready = 1'b1;
    repeat (9) tick();
    trace_ready = 1'b0;
    checks++; if (count !== 5'd7 || overflow !== 1'b1) begin errors++; $display("[TB] FAIL mid_state: got count=%0d overflow=%0b expected 7/1", count, overflow); end
    do_reset();
    checks++; if (count !== 5'd0 || trace_valid !== 1'b0 || overflow !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset: got count=%0d valid=%0b overflow=%0b expected 0/0/0", count, trace_valid, overflow); end
`ifdef WBTRACE_DROP_CNT_EN
    checks++; if (drop_count !== 16'd0) begin errors++; $display("[TB] FAIL drop_count_reset: got %0d expected 0", drop_count); end
`endif
    set_write(5'd9, 32'h55);
    tick();
    clear_write();
    checks++; if (count !== 5'd1 || trace_cycle !== 16'd0 || trace_reg !== 5'd9 || trace_data !== 32'h55) begin errors++; $display("[TB] FAIL post_reset_stamp: got count=%0d head=%0d/%0d/%h expected 1 0/9/55", count, trace_cycle, trace_reg, trace_data); end
  endtask

  // The CYCLE_W=4 copy wraps its stamp after 16 edges.
  task automatic test_wrap;
    clear_write();
    trace_ready = 1'b0;
    do_reset();
    repeat (16) tick();
    set_write(5'd3, 32'h33);
    tick();
    checks++; if (t4_valid !== 1'b1 || t4_cycle !== 4'd0 || trace_cycle !== 16'd16) begin errors++; $display("[TB] FAIL wrap_first: got valid=%0b cycle4=%0d cycle16=%0d expected 1/0/16", t4_valid, t4_cycle, trace_cycle); end
    set_write(5'd4, 32'h44);
    tick();
    clear_write();
    checks++; if (t4_count !== 3'd2 || t4_cycle !== 4'd0) begin errors++; $display("[TB] FAIL wrap_hold: got count=%0d cycle=%0d expected 2/0", t4_count, t4_cycle); end
    trace_ready = 1'b1;
    tick();
    trace_ready = 1'b0;
    checks++; if (t4_cycle !== 4'd1 || t4_reg !== 5'd4 || t4_data !== 32'h44) begin errors++; $display("[TB] FAIL wrap_second: got %0d/%0d/%h expected 1/4/44", t4_cycle, t4_reg, t4_data); end
  endtask

  initial begin
    reset = 1'b0;
    capture_en = 1'b1;
    trace_ready = 1'b0;
    clear_write();
`ifdef WBTRACE_DROP_CNT_EN
    trace_include_x0 = 1'b0;
`endif
    #2;
    test_reset();
    test_basic();
    test_x0();
    test_full();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
